// File: rtl/srl_fifo_core.sv
// First-word-fall-through FIFO over a shift-register array; the head word is picked
// out of the array by an occupancy-indexed mux so it is always visible on q.
module srl_fifo_core #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 16,
    parameter int CNT_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             wr,
    input  logic [WIDTH-1:0] d,
    output logic             full,
    input  logic             rd,
    output logic [WIDTH-1:0] q,
    output logic [CNT_W:0]   item_no,
    output logic             empty
);

    logic [DEPTH-1:0][WIDTH-1:0] srl;
    logic                        wr_en;
    logic                        rd_en;
    logic [CNT_W-1:0]            rd_idx;

    assign full  = (item_no == (CNT_W+1)'(DEPTH));
    assign empty = (item_no == '0);

    // A full FIFO still takes a write when the head leaves in the same cycle.
    assign wr_en = !rstn && wr && (!full || rd);
    assign rd_en = !rstn && rd && !empty;

    // Oldest word sits at the far end of the occupied part of the shift chain.
    assign rd_idx = CNT_W'(item_no - 1'b1);
    assign q      = empty ? '0 : srl[rd_idx];

    always_ff @(posedge clk) begin
        if (wr_en)
            srl <= {srl[DEPTH-2:0], d};
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            item_no <= '0;
        end else begin
            case ({wr_en, rd_en})
                2'b10:   item_no <= item_no + 1'b1;
                2'b01:   item_no <= item_no - 1'b1;
                default: item_no <= item_no;
            endcase
        end
    end

endmodule

// File: tb/tb_srl_fifo_core.sv
// Bench for srl_fifo_core: vector table plus hand sequences, checked against a queue model.
module tb_srl_fifo_core;
    localparam int WIDTH = 4;
    localparam int DEPTH = 16;
    localparam int CNT_W = $clog2(DEPTH);

    logic             clk = 1'b0;
    logic             rstn = 1'b1;
    logic             wr = 1'b0;
    logic             rd = 1'b0;
    logic [WIDTH-1:0] d = '0;
    logic             full;
    logic             empty;
    logic [WIDTH-1:0] q;
    logic [CNT_W:0]   item_no;

    int errors = 0;
    int checks = 0;
    logic [WIDTH-1:0] sb[$];

    srl_fifo_core #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rstn(rstn), .wr(wr), .d(d), .full(full),
        .rd(rd), .q(q), .item_no(item_no), .empty(empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit               rst;
        bit               w;
        bit               r;
        logic [WIDTH-1:0] dd;
        int               exp_items;
    } vec_t;

    vec_t vecs[17];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle from a negedge, advance the model at the posedge,
    // and compare every output against the model at the next negedge.
    task automatic cycle(input bit r, input bit w, input bit rr, input logic [WIDTH-1:0] dd);
        bit rd_en;
        bit wr_en;
        int exp_q;
        rstn = r; wr = w; rd = rr; d = dd;
        @(posedge clk);
        if (r) begin
            sb.delete();
        end else begin
            rd_en = rr && (sb.size() > 0);
            wr_en = w && ((sb.size() < DEPTH) || rr);
            if (rd_en) void'(sb.pop_front());
            if (wr_en) sb.push_back(dd);
        end
        @(negedge clk);
        exp_q = (sb.size() > 0) ? int'(sb[0]) : 0;
        chk("item_no", int'(item_no), sb.size());
        chk("empty", int'(empty), int'(sb.size() == 0));
        chk("full", int'(full), int'(sb.size() == DEPTH));
        chk("q", int'(q), exp_q);
    endtask

    initial begin
        int k;
        // Table: reset with wr/rd held, 6 writes, 5 read+write, 3 reads.
        k = 0;
        for (int i = 0; i < 3; i++) begin vecs[k] = '{1, 1, 1, 4'(i), 0}; k++; end
        for (int i = 0; i < 6; i++) begin vecs[k] = '{0, 1, 0, 4'(i), i + 1}; k++; end
        for (int i = 0; i < 5; i++) begin vecs[k] = '{0, 1, 1, 4'(6 + i), 6}; k++; end
        for (int i = 0; i < 3; i++) begin vecs[k] = '{0, 0, 1, 4'(0), 5 - i}; k++; end

        @(negedge clk);
        for (int i = 0; i < 17; i++) begin
            // During read+write, head before the edge must be 0,1,2,3,4; during drain 5,6,7.
            if (i >= 9) chk("q_pre", int'(q), i - 9);
            cycle(vecs[i].rst, vecs[i].w, vecs[i].r, vecs[i].dd);
            chk("vec_items", int'(item_no), vecs[i].exp_items);
        end

        // Fill to full, then a dropped 17th write.
        cycle(1, 0, 0, 0);
        for (int i = 0; i < DEPTH; i++) cycle(0, 1, 0, 4'(15 - i));
        chk("full_items", int'(item_no), 16);
        chk("full_flag", int'(full), 1);
        cycle(0, 1, 0, 4'hA);
        chk("drop_items", int'(item_no), 16);
        chk("drop_head", int'(q), 15);

        // Read+write while full: head advances, new word goes to the tail.
        cycle(0, 1, 1, 4'h5);
        chk("rw_full_items", int'(item_no), 16);
        chk("rw_full_head", int'(q), 14);
        for (int i = 0; i < DEPTH; i++) cycle(0, 0, 1, 0);
        chk("drained_empty", int'(empty), 1);

        // Reads while empty must not wrap the count.
        for (int i = 0; i < 4; i++) cycle(0, 0, 1, 0);
        chk("underflow_items", int'(item_no), 0);
        cycle(0, 1, 0, 4'h9);
        chk("single_q", int'(q), 9);
        chk("single_items", int'(item_no), 1);

        // Reset mid-stream at occupancy 5, then fresh data.
        for (int i = 0; i < 4; i++) cycle(0, 1, 0, 4'(i + 3));
        chk("pre_rst_items", int'(item_no), 5);
        cycle(1, 1, 1, 4'hF);
        chk("mid_rst_items", int'(item_no), 0);
        chk("mid_rst_empty", int'(empty), 1);
        for (int i = 0; i < 3; i++) cycle(0, 1, 0, 4'(12 + i));
        chk("post_rst_head", int'(q), 12);
        for (int i = 0; i < 3; i++) cycle(0, 0, 1, 0);
        chk("post_rst_empty", int'(empty), 1);

        // Random traffic against the scoreboard.
        for (int i = 0; i < 300; i++)
            cycle(($urandom_range(0, 49) == 0), $urandom_range(0, 1), $urandom_range(0, 1),
                  4'($urandom_range(0, 15)));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
